// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: datapath widths, opcode map and
// instruction field helpers.
package instruction_fetch_pkg;

  localparam int unsigned AddrWidth   = 16;
  localparam int unsigned InstrWidth  = 28;
  localparam int unsigned OpcodeWidth = 4;

  // Instruction layout: [27:24] opcode, [23:16] short operand (JMP target), [15:0] rest
  localparam int unsigned OpcodeLsb   = InstrWidth - OpcodeWidth;
  localparam int unsigned JmpTgtWidth = 8;
  localparam int unsigned JmpTgtLsb   = OpcodeLsb - JmpTgtWidth;

  typedef enum logic [OpcodeWidth-1:0] {
    OpNop   = 4'h0,
    OpAdd   = 4'h1,
    OpSub   = 4'h2,
    OpAnd   = 4'h3,
    OpOr    = 4'h4,
    OpLoad  = 4'h5,
    OpStore = 4'h6,
    OpBle   = 4'h7,
    OpJmp   = 4'h8
  } opcode_e;

  function automatic logic [OpcodeWidth-1:0] get_opcode(input logic [InstrWidth-1:0] instr);
    return instr[InstrWidth-1:OpcodeLsb];
  endfunction

  function automatic logic [AddrWidth-1:0] get_jmp_target(input logic [InstrWidth-1:0] instr);
    return {{(AddrWidth - JmpTgtWidth){1'b0}}, instr[OpcodeLsb-1:JmpTgtLsb]};
  endfunction

endpackage

// File: rtl/instruction_fetch_pc_register.sv
// Program counter register: parallel load takes priority over increment,
// increment wraps silently at the top of the address space.
module instruction_fetch_pc_register #(
  parameter int unsigned Width = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_value,
  input  logic             i_incr,
  output logic [Width-1:0] o_pc
);

  logic [Width-1:0] r_pc;

  // PC update: load wins over increment, otherwise hold
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc <= '0;
    end else if (i_load) begin
      r_pc <= i_load_value;
    end else if (i_incr) begin
      r_pc <= r_pc + Width'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives the PC to an asynchronous ROM, registers the
// returned instruction for decode, consumes JMPs internally and honours
// stall, halt and execute-stage redirects.
module instruction_fetch
  import instruction_fetch_pkg::*;
(
  input  logic                  Clock,
  input  logic                  Reset,
  output logic [AddrWidth-1:0]  oRomAddress,
  input  logic [InstrWidth-1:0] iRomInstruction,
  output logic [InstrWidth-1:0] oInstruction,
  output logic [AddrWidth-1:0]  oInstructionPC,
  output logic                  oValid,
  input  logic                  iReady,
  input  logic                  iRedirect,
  input  logic [AddrWidth-1:0]  iRedirectTarget,
  input  logic                  iHalt
);

  typedef enum logic [1:0] {
    StBoot   = 2'd0,
    StRun    = 2'd1,
    StHalted = 2'd2
  } state_e;

  state_e r_state, w_state_next;

  logic [AddrWidth-1:0]  w_pc;
  logic                  w_pc_load;
  logic [AddrWidth-1:0]  w_pc_load_value;
  logic                  w_pc_incr;
  logic                  w_redirect;
  logic                  w_fetch;
  logic                  w_is_jmp;

  logic [InstrWidth-1:0] r_instr, w_instr_next;
  logic [AddrWidth-1:0]  r_instr_pc, w_instr_pc_next;
  logic                  r_valid, w_valid_next;

  instruction_fetch_pc_register #(
    .Width(AddrWidth)
  ) u_pc_register (
    .i_clk       (Clock),
    .i_rst_n     (Reset),
    .i_load      (w_pc_load),
    .i_load_value(w_pc_load_value),
    .i_incr      (w_pc_incr),
    .o_pc        (w_pc)
  );

  assign oRomAddress = w_pc;

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= StBoot;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: one boot cycle, then halt toggles between run and halted
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StBoot:   w_state_next = StRun;
      StRun:    if (iHalt) w_state_next = StHalted;
      StHalted: if (!iHalt) w_state_next = StRun;
      default:  w_state_next = StBoot;
    endcase
  end

  // Redirects are dropped while booting; a fetch also needs the output slot free
  assign w_redirect = iRedirect && (r_state != StBoot);
  assign w_fetch    = (r_state == StRun) && !iHalt && !iRedirect && (!r_valid || iReady);
  assign w_is_jmp   = (get_opcode(iRomInstruction) == OpJmp);

  // Datapath next-state: redirect beats fetch; JMPs retarget the PC and leave a bubble
  always_comb begin
    w_pc_load       = 1'b0;
    w_pc_load_value = w_pc;
    w_pc_incr       = 1'b0;
    w_instr_next    = r_instr;
    w_instr_pc_next = r_instr_pc;
    w_valid_next    = r_valid;
    if (w_redirect) begin
      w_pc_load       = 1'b1;
      w_pc_load_value = iRedirectTarget;
      w_valid_next    = 1'b0;
    end else if (w_fetch) begin
      if (w_is_jmp) begin
        w_pc_load       = 1'b1;
        w_pc_load_value = get_jmp_target(iRomInstruction);
        w_valid_next    = 1'b0;
      end else begin
        w_pc_incr       = 1'b1;
        w_instr_next    = iRomInstruction;
        w_instr_pc_next = w_pc;
        w_valid_next    = 1'b1;
      end
    end
  end

  // Output register presented to decode
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_instr    <= w_instr_next;
      r_instr_pc <= w_instr_pc_next;
      r_valid    <= w_valid_next;
    end
  end

  assign oInstruction   = r_instr;
  assign oInstructionPC = r_instr_pc;
  assign oValid         = r_valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a vector table covers straight-line
// fetch, stall, JMP, redirect, wrap and halt; hand-written sequences cover
// reset and redirect-during-boot.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic                  Clock;
  logic                  Reset;
  logic [AddrWidth-1:0]  oRomAddress;
  logic [InstrWidth-1:0] iRomInstruction;
  logic [InstrWidth-1:0] oInstruction;
  logic [AddrWidth-1:0]  oInstructionPC;
  logic                  oValid;
  logic                  iReady;
  logic                  iRedirect;
  logic [AddrWidth-1:0]  iRedirectTarget;
  logic                  iHalt;

  int n_checks = 0;
  int n_errors = 0;

  instruction_fetch dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .oRomAddress    (oRomAddress),
    .iRomInstruction(iRomInstruction),
    .oInstruction   (oInstruction),
    .oInstructionPC (oInstructionPC),
    .oValid         (oValid),
    .iReady         (iReady),
    .iRedirect      (iRedirect),
    .iRedirectTarget(iRedirectTarget),
    .iHalt          (iHalt)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ROM image: a JMP to 2 at address 17, distinct ALU words everywhere else
  function automatic logic [InstrWidth-1:0] rom_f(input logic [AddrWidth-1:0] a);
    logic [3:0] op;
    if (a == 16'd17) begin
      op = OpJmp;
      return {op, 8'd2, 16'h0000};
    end
    op = OpAdd;
    return {op, a[7:0] ^ 8'h5A, a};
  endfunction

  always_comb iRomInstruction = rom_f(oRomAddress);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [15:0] tgt;
    logic        halt;
    logic        exp_valid;
    logic [15:0] exp_ipc;
    logic [15:0] exp_addr;
  } vec_t;

  localparam int NVec = 26;
  vec_t vecs[NVec];

  initial begin
    // {rdy, redir, tgt, halt, exp_valid, exp_ipc, exp_addr} observed after the edge
    vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000}; // boot edge
    vecs[1]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0001};
    vecs[2]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0001, 16'h0002};
    vecs[3]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0002, 16'h0003};
    vecs[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0003, 16'h0004};
    vecs[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004, 16'h0005};
    vecs[6]  = '{1'b1, 1'b1, 16'h0002, 1'b0, 1'b0, 16'h0004, 16'h0002}; // redirect to 2
    vecs[7]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0002, 16'h0003};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0002, 16'h0003}; // stall x3
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0002, 16'h0003};
    vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0002, 16'h0003};
    vecs[11] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0003, 16'h0004};
    vecs[12] = '{1'b1, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0003, 16'h0010}; // go to 16
    vecs[13] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0010, 16'h0011};
    vecs[14] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0010, 16'h0002}; // JMP consumed
    vecs[15] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0002, 16'h0003};
    vecs[16] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0002, 16'h0003};
    vecs[17] = '{1'b0, 1'b1, 16'h000A, 1'b0, 1'b0, 16'h0002, 16'h000A}; // redirect in stall
    vecs[18] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h000A, 16'h000B};
    vecs[19] = '{1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h000A, 16'hFFFF};
    vecs[20] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 16'h0000}; // wrap
    vecs[21] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0001};
    vecs[22] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0001}; // halt x2
    vecs[23] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0001};
    vecs[24] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0001}; // leaving HALTED
    vecs[25] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0001, 16'h0002};

    Reset           = 1'b0;
    iReady          = 1'b1;
    iRedirect       = 1'b0;
    iRedirectTarget = '0;
    iHalt           = 1'b0;

    step();
    step();
    check("reset valid", 32'(oValid), 32'd0);
    check("reset instr", 32'(oInstruction), 32'd0);
    check("reset ipc", 32'(oInstructionPC), 32'd0);
    check("reset addr", 32'(oRomAddress), 32'd0);
    Reset = 1'b1;

    for (int i = 0; i < NVec; i++) begin
      iReady          = vecs[i].rdy;
      iRedirect       = vecs[i].redir;
      iRedirectTarget = vecs[i].tgt;
      iHalt           = vecs[i].halt;
      step();
      check($sformatf("v%0d valid", i), 32'(oValid), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d ipc", i), 32'(oInstructionPC), 32'(vecs[i].exp_ipc));
      check($sformatf("v%0d addr", i), 32'(oRomAddress), 32'(vecs[i].exp_addr));
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d instr", i), 32'(oInstruction), 32'(rom_f(vecs[i].exp_ipc)));
      end
    end

    // Mid-stream reset clears outputs without waiting for a clock edge
    #2;
    Reset = 1'b0;
    #1;
    check("async rst valid", 32'(oValid), 32'd0);
    check("async rst instr", 32'(oInstruction), 32'd0);
    check("async rst ipc", 32'(oInstructionPC), 32'd0);
    check("async rst addr", 32'(oRomAddress), 32'd0);
    step();
    check("held rst valid", 32'(oValid), 32'd0);

    // Redirect presented on the boot edge must be ignored
    Reset           = 1'b1;
    iReady          = 1'b1;
    iRedirect       = 1'b1;
    iRedirectTarget = 16'd50;
    step();
    check("boot valid", 32'(oValid), 32'd0);
    check("boot ignores redirect", 32'(oRomAddress), 32'd0);
    iRedirect = 1'b0;
    step();
    check("restart valid", 32'(oValid), 32'd1);
    check("restart ipc", 32'(oInstructionPC), 32'd0);
    check("restart instr", 32'(oInstruction), 32'(rom_f(16'd0)));
    check("restart addr", 32'(oRomAddress), 32'd1);
    step();
    check("restart next ipc", 32'(oInstructionPC), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
